// File: rtl/nor_logic_unit.sv
// Registered stream logic unit: eight bitwise functions built purely from 2-input NOR
// primitives, with single-beat evaluation and multi-beat packet reduction.
module nor_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       op_q, op_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             out_valid_n;
    logic [WIDTH-1:0] out_y_n;
    logic [CNT_W-1:0] out_count_n;

    logic [WIDTH-1:0] fx, fy, f_res;
    logic [2:0]       f_op;
    logic             accept;

    // During a packet the core folds the accumulator with the new operand under the latched op.
    assign fx   = (state == S_ACC) ? acc  : in_a;
    assign fy   = (state == S_ACC) ? in_a : in_b;
    assign f_op = (state == S_ACC) ? op_q : in_op;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        logic nx, ny, n_or, f_or, f_and, f_nand, n_xa, n_xb, f_xnor, f_xor, f_pass;
        logic res_b;

        assign nx     = ~(fx[i] | fx[i]);
        assign ny     = ~(fy[i] | fy[i]);
        assign n_or   = ~(fx[i] | fy[i]);
        assign f_or   = ~(n_or | n_or);
        assign f_and  = ~(nx | ny);
        assign f_nand = ~(f_and | f_and);
        assign n_xa   = ~(fx[i] | n_or);
        assign n_xb   = ~(fy[i] | n_or);
        assign f_xnor = ~(n_xa | n_xb);
        assign f_xor  = ~(f_xnor | f_xnor);
        assign f_pass = ~(nx | nx);

        always_comb begin
            res_b = f_pass;
            case (f_op)
                3'd0:    res_b = nx;
                3'd1:    res_b = f_and;
                3'd2:    res_b = f_or;
                3'd3:    res_b = f_nand;
                3'd4:    res_b = n_or;
                3'd5:    res_b = f_xor;
                3'd6:    res_b = f_xnor;
                default: res_b = f_pass;
            endcase
        end

        assign f_res[i] = res_b;
    end

    // Intermediate packet beats never touch the output register, so they bypass backpressure.
    assign in_ready = ((state == S_ACC) && !in_last) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n     = state;
        op_n        = op_q;
        acc_n       = acc;
        cnt_n       = cnt;
        out_valid_n = out_valid;
        out_y_n     = out_y;
        out_count_n = out_count;

        if (out_ready) begin
            out_valid_n = 1'b0;
        end

        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (!in_mode) begin
                        out_y_n     = f_res;
                        out_count_n = CNT_ONE;
                        out_valid_n = 1'b1;
                    end else begin
                        op_n  = in_op;
                        acc_n = f_res;
                        cnt_n = CNT_ONE;
                        if (in_last) begin
                            out_y_n     = f_res;
                            out_count_n = CNT_ONE;
                            out_valid_n = 1'b1;
                        end else begin
                            state_n = S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    acc_n = f_res;
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    if (in_last) begin
                        out_y_n     = f_res;
                        out_count_n = cnt_n;
                        out_valid_n = 1'b1;
                        state_n     = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= 3'd0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_valid <= out_valid_n;
            out_y     <= out_y_n;
            out_count <= out_count_n;
        end
    end

endmodule
